dff_pipe: RTL and testbench

- Parametrised successor to the single-bit DFF: a WIDTH-bit, DEPTH-stage register pipeline with per-stage valid bits.
- Adds an advance enable (stall), a synchronous flush and a programmable reset value, none of which the single-bit DFF has.
- Used in the music player datapath to delay note/sample words by a fixed number of cycles, for example to align note data with the tone-generator latency.

---
 rtl/dff_pipe.sv | 82 ++++++++
 tb/tb_dff_pipe.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/dff_pipe.sv
// WIDTH-bit, DEPTH-stage register pipeline with per-stage valid bits, stall enable, synchronous flush and programmable reset value.
// Latency DEPTH enabled cycles, no backpressure (en=0 holds everything). Optional occupancy counter under DFF_PIPE_OCC_EN.
module dff_pipe #(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic             in_val,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_val,
  output logic [WIDTH-1:0] out_data
`ifdef DFF_PIPE_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occ
`endif
);

  logic [DEPTH-1:0]            r_val;
  logic [DEPTH-1:0][WIDTH-1:0] r_data;
  logic [DEPTH-1:0]            w_val_nxt;
  logic [DEPTH-1:0][WIDTH-1:0] w_data_nxt;

  // Flush outranks the enable; with en=0 the inputs are ignored entirely.
  always_comb begin
    w_val_nxt  = r_val;
    w_data_nxt = r_data;
    if (flush) begin
      w_val_nxt  = '0;
      w_data_nxt = {DEPTH{RST_VAL}};
    end else if (en) begin
      w_val_nxt[0]  = in_val;
      w_data_nxt[0] = in_data;
      for (int i = 1; i < DEPTH; i++) begin
        w_val_nxt[i]  = r_val[i-1];
        w_data_nxt[i] = r_data[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_val  <= '0;
      r_data <= {DEPTH{RST_VAL}};
    end else begin
      r_val  <= w_val_nxt;
      r_data <= w_data_nxt;
    end
  end

  assign out_val  = r_val[DEPTH-1];
  assign out_data = r_data[DEPTH-1];

`ifdef DFF_PIPE_OCC_EN
  localparam int OCC_W = $clog2(DEPTH+1);

  logic [OCC_W-1:0] r_occ;
  logic [OCC_W-1:0] w_occ_nxt;

  // Popcount of the next valid vector keeps occ aligned with the stages.
  always_comb begin
    w_occ_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_occ_nxt = w_occ_nxt + OCC_W'(w_val_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_occ <= '0;
    end else begin
      r_occ <= w_occ_nxt;
    end
  end

  assign occ = r_occ;
`endif

endmodule

// File: tb/tb_dff_pipe.sv
// Directed, table-driven bench for dff_pipe: DEPTH=3 pipe with RST_VAL=8'hA5 and a DEPTH=1 pipe against a single-DFF model.
module tb_dff_pipe;

  logic       clk;
  logic       reset;
  logic       en, flush, in_val;
  logic [7:0] in_data;
  logic       out_val;
  logic [7:0] out_data;
  logic       en1, flush1, in_val1;
  logic [7:0] in_data1;
  logic       out_val1;
  logic [7:0] out_data1;
`ifdef DFF_PIPE_OCC_EN
  logic [1:0] occ;
  logic [0:0] occ1;
`endif

  int checks = 0;
  int errors = 0;

  dff_pipe #(.WIDTH(8), .DEPTH(3), .RST_VAL(8'hA5)) u_dut3 (
    .clk(clk), .reset(reset), .en(en), .flush(flush), .in_val(in_val), .in_data(in_data),
    .out_val(out_val), .out_data(out_data)
`ifdef DFF_PIPE_OCC_EN
    , .occ(occ)
`endif
  );

  dff_pipe #(.WIDTH(8), .DEPTH(1), .RST_VAL(8'h3C)) u_dut1 (
    .clk(clk), .reset(reset), .en(en1), .flush(flush1), .in_val(in_val1), .in_data(in_data1),
    .out_val(out_val1), .out_data(out_data1)
`ifdef DFF_PIPE_OCC_EN
    , .occ(occ1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       en;
    bit       flush;
    bit       iv;
    bit [7:0] id;
    bit       ev;
    bit [7:0] ed;
    int       eocc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit e, input bit f, input bit iv, input bit [7:0] id,
                     input bit ev, input bit [7:0] ed, input int eocc);
    vec_t v;
    v.en = e; v.flush = f; v.iv = iv; v.id = id; v.ev = ev; v.ed = ed; v.eocc = eocc;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic       m_val;
  logic [7:0] m_data;

  initial begin
    reset = 1'b1;
    en = 0; flush = 0; in_val = 0; in_data = 8'h00;
    en1 = 0; flush1 = 0; in_val1 = 0; in_data1 = 8'h00;
    #2 reset = 1'b0;
    #1;
    chk("rst_out_val", 32'(out_val), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'hA5);
    chk("rst1_out_val", 32'(out_val1), 32'd0);
    chk("rst1_out_data", 32'(out_data1), 32'h3C);
`ifdef DFF_PIPE_OCC_EN
    chk("rst_occ", 32'(occ), 32'd0);
`endif
    step();
    step();
    reset = 1'b1;

    // Streaming
    add(1,0,1,8'h11, 0,8'hA5, 1);
    add(1,0,1,8'h22, 0,8'hA5, 2);
    add(1,0,1,8'h33, 1,8'h11, 3);
    add(1,0,0,8'h00, 1,8'h22, 2);
    add(1,0,0,8'h00, 1,8'h33, 1);
    add(1,0,0,8'h00, 0,8'h00, 0);
    // Bubbles 1,0,1
    add(1,0,1,8'h01, 0,8'h00, 1);
    add(1,0,0,8'h02, 0,8'h00, 1);
    add(1,0,1,8'h03, 1,8'h01, 2);
    add(1,0,0,8'h00, 0,8'h02, 1);
    add(1,0,0,8'h00, 1,8'h03, 1);
    add(1,0,0,8'h00, 0,8'h00, 0);
    // Stall with 8'h44 in stage 0
    add(1,0,1,8'h44, 0,8'h00, 1);
    for (int k = 0; k < 4; k++) add(0,0,1,8'hFF, 0,8'h00, 1);
    add(1,0,0,8'h00, 0,8'h00, 1);
    add(1,0,0,8'h00, 1,8'h44, 1);
    add(1,0,0,8'h00, 0,8'h00, 0);
    // Flush priority over en
    add(1,0,1,8'h55, 0,8'h00, 1);
    add(1,0,1,8'h66, 0,8'h00, 2);
    add(1,0,1,8'h77, 1,8'h55, 3);
    add(1,1,1,8'h88, 0,8'hA5, 0);
    add(1,0,0,8'h00, 0,8'hA5, 0);
    add(1,0,0,8'h00, 0,8'hA5, 0);
    add(1,0,0,8'h00, 0,8'h00, 0);
    add(0,1,1,8'h99, 0,8'hA5, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      en = vecs[i].en; flush = vecs[i].flush; in_val = vecs[i].iv; in_data = vecs[i].id;
      step();
      chk($sformatf("vec%0d_val", i), 32'(out_val), 32'(vecs[i].ev));
      chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(vecs[i].ed));
`ifdef DFF_PIPE_OCC_EN
      chk($sformatf("vec%0d_occ", i), 32'(occ), 32'(vecs[i].eocc));
`endif
    end

    // Mid-cycle reset with a full pipeline clears before the next edge
    en = 1; flush = 0; in_val = 1;
    in_data = 8'hC1; step();
    in_data = 8'hC2; step();
    in_data = 8'hC3; step();
    chk("full_out_val", 32'(out_val), 32'd1);
    chk("full_out_data", 32'(out_data), 32'hC1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_out_val", 32'(out_val), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'hA5);
`ifdef DFF_PIPE_OCC_EN
    chk("midrst_occ", 32'(occ), 32'd0);
`endif
    step();
    chk("rst_dom_out_val", 32'(out_val), 32'd0);
    chk("rst_dom_out_data", 32'(out_data), 32'hA5);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_val = 0; in_data = 8'h0F;
      step();
      chk($sformatf("post_rst%0d_val", k), 32'(out_val), 32'd0);
      chk($sformatf("post_rst%0d_data", k), 32'(out_data), (k == 2) ? 32'h0F : 32'hA5);
    end
    en = 0;

    // DEPTH=1 exhaustive over {en, flush, in_val, in_data[0]}
    m_val = 1'b0;
    m_data = 8'h3C;
    for (int p = 0; p < 32; p++) begin
      int unsigned ix;
      logic [3:0] b;
      ix = (p < 16) ? p : 31 - p;
      b = 4'(ix);
      en1 = b[3]; flush1 = b[2]; in_val1 = b[1];
      in_data1 = {b, 3'b101, b[0]};
      step();
      if (flush1) begin
        m_val = 1'b0; m_data = 8'h3C;
      end else if (en1) begin
        m_val = in_val1; m_data = in_data1;
      end
      chk($sformatf("d1_%0d_val", p), 32'(out_val1), 32'(m_val));
      chk($sformatf("d1_%0d_data", p), 32'(out_data1), 32'(m_data));
`ifdef DFF_PIPE_OCC_EN
      chk($sformatf("d1_%0d_occ", p), 32'(occ1), 32'(m_val));
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
